// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code encodings and the
// multiply/divide sequencing states.
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_NOR   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_JR    = 5'd11;
  localparam logic [4:0] OP_NOP   = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
  localparam logic [4:0] OP_SLTU  = 5'd19;

  // Explicit encoding keeps the state register layout stable for legacy tooling.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result bus between the pipeline controller and the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op_code;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, op_code, reg1, reg2, shamt,
    input  in_ready, out_valid, result, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, op_code, reg1, reg2, shamt,
    output in_ready, out_valid, result, overflow, div_by_zero
  );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide engine: one bit per cycle on operand magnitudes,
// followed by a single sign fix-up cycle in which done is asserted.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_mul,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   op_b;
  logic               mode_mul;
  logic               neg_res;
  logic               neg_rem;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   div_rem;

  assign a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: upper half accumulates the multiplicand while the multiplier
  // shifts out of the lower half, LSB first.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : '0);

  // Divide: upper half is the partial remainder, lower half shifts the
  // dividend out and the quotient in.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, op_b};
  assign div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];

  always_comb begin
    acc_next = acc;
    case (state)
      MUL:     acc_next = {mul_sum, acc[WIDTH-1:1]};
      DIV:     acc_next = {div_rem, acc[WIDTH-2:0], ~div_diff[WIDTH]};
      default: acc_next = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      op_b     <= '0;
      mode_mul <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here sees pre-edge values of the others.
      case (state)
        IDLE: begin
          if (start) begin
            state    <= op_mul ? MUL : DIV;
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, a_mag};
            op_b     <= b_mag;
            mode_mul <= op_mul;
            neg_res  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= op_signed && a[WIDTH-1];
          end
        end
        MUL, DIV: begin
          acc <= acc_next;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign prod    = neg_res ? -acc : acc;
  assign quo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign hi   = mode_mul ? prod[2*WIDTH-1:WIDTH] : rem_fix;
  assign lo   = mode_mul ? prod[WIDTH-1:0]       : quo_fix;
  assign busy = (state != IDLE);
  assign done = (state == FIX);

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU: registered single-cycle ops, HI/LO registers and the
// valid/ready handshake around the iterative multiply/divide engine.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  logic [SHW-1:0]   sh;
  logic             accept;
  logic             op_is_mul;
  logic             op_is_div;
  logic             start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic             overflow_q;
  logic             dbz_q;

  assign sh        = bus.shamt;
  assign op_is_mul = is_mul_op(bus.op_code);
  assign op_is_div = is_div_op(bus.op_code);
  assign accept    = bus.in_valid && bus.in_ready;
  // Division by zero never enters the engine; it completes as a single-cycle op.
  assign start     = accept && (op_is_mul || (op_is_div && (bus.reg2 != '0)));

  alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_mul    (op_is_mul),
    .op_signed ((bus.op_code == OP_MULT) || (bus.op_code == OP_DIV)),
    .a         (bus.reg1),
    .b         (bus.reg2),
    .busy      (md_busy),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             dbz_c;

  assign sum = bus.reg1 + bus.reg2;
  assign dif = bus.reg1 - bus.reg2;

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    res_c = '0;
    ovf_c = 1'b0;
    dbz_c = 1'b0;
    case (bus.op_code)
      OP_ADD: begin
        res_c = sum;
        ovf_c = (bus.reg1[WIDTH-1] == bus.reg2[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.reg1[WIDTH-1]);
      end
      OP_ADDU: res_c = sum;
      OP_SUB: begin
        res_c = dif;
        ovf_c = (bus.reg1[WIDTH-1] != bus.reg2[WIDTH-1]) &&
                (dif[WIDTH-1] != bus.reg1[WIDTH-1]);
      end
      OP_SUBU: res_c = dif;
      OP_AND:  res_c = bus.reg1 & bus.reg2;
      OP_OR:   res_c = bus.reg1 | bus.reg2;
      OP_NOR:  res_c = ~(bus.reg1 | bus.reg2);
      OP_SLT:  res_c = WIDTH'($signed(bus.reg1) < $signed(bus.reg2));
      OP_SLTU: res_c = WIDTH'(bus.reg1 < bus.reg2);
      OP_SLL:  res_c = bus.reg1 << sh;
      OP_SRL:  res_c = bus.reg1 >> sh;
      OP_SRA:  res_c = WIDTH'($signed(bus.reg1) >>> sh);
      OP_JR:   res_c = bus.reg1;
      OP_MFHI: res_c = hi_q;
      OP_MFLO: res_c = lo_q;
      OP_DIV, OP_DIVU: begin
        res_c = '0;
        dbz_c = (bus.reg2 == '0);
      end
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
      if (md_done) begin
        hi_q        <= md_hi;
        lo_q        <= md_lo;
        result_q    <= md_lo;
        out_valid_q <= 1'b1;
      end else if (accept && !start) begin
        result_q    <= res_c;
        overflow_q  <= ovf_c;
        dbz_q       <= dbz_c;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = !md_busy;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic on the architectural rules.
  function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [31:0] hi,
                                 input logic [31:0] lo);
    exp_t e;
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    e.res = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.hi = hi; e.lo = lo;
    case (op)
      0:  begin p = sa + sb; e.res = p[31:0]; e.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648); end
      1:  e.res = a + b;
      2:  begin p = sa - sb; e.res = p[31:0]; e.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648); end
      3:  e.res = a - b;
      4:  e.res = a & b;
      5:  e.res = a | b;
      6:  e.res = ~(a | b);
      7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      8:  e.res = a << sh;
      9:  e.res = a >> sh;
      10: begin p = sa >>> sh; e.res = p[31:0]; end
      11: e.res = a;
      13: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; e.res = e.lo; end
      14: begin p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; e.res = e.lo; end
      15: begin
        if (b == 32'd0) e.dbz = 1'b1;
        else begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; e.res = e.lo; end
      end
      16: begin
        if (b == 32'd0) e.dbz = 1'b1;
        else begin q = ua / ub; r = ua % ub; e.lo = q[31:0]; e.hi = r[31:0]; e.res = e.lo; end
      end
      17: e.res = hi;
      18: e.res = lo;
      19: e.res = (ua < ub) ? 32'd1 : 32'd0;
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Issue one op from the current time; returns just after out_valid is expected.
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh);
    exp_t e;
    int edges;
    logic rdy_ok;
    logic multi;
    e = model(int'(op), a, b, sh, m_hi, m_lo);
    multi = (op == OP_MULT) || (op == OP_MULTU) ||
            (((op == OP_DIV) || (op == OP_DIVU)) && (b != 32'd0));
    check_bit($sformatf("ready_before op%0d", op), bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.op_code  = op;
    bus.reg1     = a;
    bus.reg2     = b;
    bus.shamt    = sh;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.reg1     = $urandom;
    bus.reg2     = $urandom;
    if (multi) begin
      edges  = 0;
      rdy_ok = 1'b1;
      while (bus.out_valid !== 1'b1 && edges < 40) begin
        if (bus.in_ready !== 1'b0) rdy_ok = 1'b0;
        @(posedge clk);
        #1;
        edges++;
      end
      check($sformatf("latency op%0d", op), edges, 33);
      check_bit($sformatf("busy_ready_low op%0d", op), rdy_ok, 1'b1);
    end
    check_bit($sformatf("out_valid op%0d", op), bus.out_valid, 1'b1);
    check($sformatf("result op%0d", op), bus.result, e.res);
    check_bit($sformatf("overflow op%0d", op), bus.overflow, e.ovf);
    check_bit($sformatf("div_by_zero op%0d", op), bus.div_by_zero, e.dbz);
    check_bit($sformatf("ready_after op%0d", op), bus.in_ready, 1'b1);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check_bit({tag, " out_valid_drop"}, bus.out_valid, 1'b0);
    check_bit({tag, " overflow_idle"}, bus.overflow, 1'b0);
    check_bit({tag, " dbz_idle"}, bus.div_by_zero, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw_pulse;
    logic [4:0] rop;
    logic [31:0] ra, rb;

    bus.in_valid = 1'b0;
    bus.op_code  = '0;
    bus.reg1     = '0;
    bus.reg2     = '0;
    bus.shamt    = '0;

    repeat (2) @(negedge clk);
    check_bit("reset in_ready", bus.in_ready, 1'b1);
    check_bit("reset out_valid", bus.out_valid, 1'b0);
    check("reset result", bus.result, 32'h0);
    check_bit("reset overflow", bus.overflow, 1'b0);
    check_bit("reset div_by_zero", bus.div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run(OP_MFHI, 32'h0, 32'h0, 5'd0);
    check("reset hi", bus.result, 32'h0);
    run(OP_MFLO, 32'h0, 32'h0, 5'd0);
    check("reset lo", bus.result, 32'h0);

    run(OP_SRA, 32'h8000_0000, 32'h0, 5'd4);
    check("sra directed", bus.result, 32'hF800_0000);
    run(OP_SRL, 32'h8000_0000, 32'h0, 5'd4);
    check("srl directed", bus.result, 32'h0800_0000);
    idle_check("shift");

    run(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
    check_bit("add overflow directed", bus.overflow, 1'b1);
    run(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0);
    check_bit("addu no overflow directed", bus.overflow, 1'b0);
    check("addu result directed", bus.result, 32'h8000_0000);
    idle_check("add");

    run(OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check("slt directed", bus.result, 32'h1);
    run(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check("sltu directed", bus.result, 32'h0);
    idle_check("slt");

    run(OP_SUB, 32'h8000_0000, 32'h1, 5'd0);
    run(OP_SUBU, 32'h8000_0000, 32'h1, 5'd0);

    run(OP_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0);
    run(OP_MFHI, 32'h0, 32'h0, 5'd0);
    check("mult hi directed", bus.result, 32'hFFFF_FFFF);
    run(OP_MFLO, 32'h0, 32'h0, 5'd0);
    check("mult lo directed", bus.result, 32'hFFFF_FFF1);

    run(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0);
    run(OP_MFHI, 32'h0, 32'h0, 5'd0);
    check("multu hi directed", bus.result, 32'h1);
    run(OP_MFLO, 32'h0, 32'h0, 5'd0);
    check("multu lo directed", bus.result, 32'hFFFF_FFFE);

    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
    run(OP_MFLO, 32'h0, 32'h0, 5'd0);
    check("div lo directed", bus.result, 32'hFFFF_FFFD);
    run(OP_MFHI, 32'h0, 32'h0, 5'd0);
    check("div hi directed", bus.result, 32'hFFFF_FFFF);

    run(OP_DIVU, 32'd7, 32'd0, 5'd0);
    check_bit("divu by zero flag", bus.div_by_zero, 1'b1);
    check("divu by zero result", bus.result, 32'h0);
    run(OP_MFHI, 32'h0, 32'h0, 5'd0);
    check("dbz hi kept", bus.result, 32'hFFFF_FFFF);
    run(OP_MFLO, 32'h0, 32'h0, 5'd0);
    check("dbz lo kept", bus.result, 32'hFFFF_FFFD);
    idle_check("dbz");

    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    check("minneg div quotient", bus.result, 32'h8000_0000);
    run(OP_MFHI, 32'h0, 32'h0, 5'd0);
    check("minneg div remainder", bus.result, 32'h0);

    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run(rop, ra, rb, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 1) idle_check("random");
    end

    run(OP_MULT, 32'h1234_5678, 32'h0000_0100, 5'd0);
    bus.in_valid = 1'b1;
    bus.op_code  = OP_MULT;
    bus.reg1     = 32'hFFFF_FFF0;
    bus.reg2     = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_bit("abort in_ready", bus.in_ready, 1'b1);
    check_bit("abort out_valid", bus.out_valid, 1'b0);
    check("abort result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    saw_pulse = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) saw_pulse = 1'b1;
    end
    check_bit("abort no late pulse", saw_pulse, 1'b0);
    run(OP_MFHI, 32'h0, 32'h0, 5'd0);
    check("abort hi cleared", bus.result, 32'h0);
    run(OP_MFLO, 32'h0, 32'h0, 5'd0);
    check("abort lo cleared", bus.result, 32'h0);
    idle_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle datapath ALU. Executes all single-cycle ALU ops with a registered result, adds a working arithmetic right shift, signed/unsigned set-less-than and signed-overflow detection, and adds an iterative multiply/divide unit with HI/LO registers (mult, multu, div, divu, mfhi, mflo). Sits in the execute stage; the pipeline controller issues ops through a valid/ready handshake and stalls while the block is busy.

## Interface

- WIDTH, 32, datapath width (≥ 8, even)
- SHW, $clog2(WIDTH), shift-amount width
- clk  in  1  system clock; the block uses one clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  op offered this cycle
- in_ready  out  1  block can accept an op (state IDLE)
- op_code  in  5  operation select
- reg1, reg2  in  WIDTH  operands (rs, rt)
- shamt  in  SHW  shift amount
- out_valid  out  1  one-cycle pulse: result/flags valid
- result  out  WIDTH  registered result
- overflow  out  1  signed overflow (add/sub only), valid with out_valid
- div_by_zero  out  1  div/divu with reg2 == 0, valid with out_valid

## Operation

- Op codes: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 nor, 7 slt (signed), 8 sll, 9 srl, 10 sra, 11 jr (pass reg1), 12 nop (0), 13 mult, 14 multu, 15 div, 16 divu, 17 mfhi, 18 mflo, 19 sltu. Codes 20–31: result 0, no flags.
- An op is accepted on a rising edge with in_valid && in_ready.
- Single-cycle ops (0–12, 17–19, and div/divu with reg2 == 0): the FSM stays in IDLE and back-to-back issue is allowed.
- add/sub: result wraps modulo 2^WIDTH. overflow = 1 on signed overflow. addu/subu never set overflow.
- FSM states:
  - IDLE → MUL on mult/multu.
  - IDLE → DIV on div/divu with reg2 ≠ 0.
  - MUL/DIV iterate for exactly WIDTH cycles on a counter (0..WIDTH-1), then → FIX.
  - FIX → IDLE.
- MUL: shift-add on operand magnitudes, one bit per cycle, 2·WIDTH-bit accumulator.
- DIV: restoring division on magnitudes, one quotient bit per cycle.
- FIX (signed ops only) applies sign correction:
  - product negated if the operand signs differ;
  - quotient truncates toward zero (negated if signs differ);
  - remainder takes the sign of the dividend.
- FIX then writes HI/LO:
  - mult/multu: HI = upper product, LO = lower product.
  - div/divu: LO = quotient, HI = remainder.
  - It pulses out_valid with result = LO.
- Divide by zero: HI/LO unchanged, result 0, div_by_zero = 1.
- Signed most-negative / −1: quotient = most-negative, remainder 0, no flag.
- mfhi/mflo return the current HI/LO. They cannot be accepted while busy because in_ready = 0.
- Operands are latched on accept. Input changes during MUL/DIV are ignored.

## Timing

- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, overflow 0, div_by_zero 0, HI 0, LO 0, counter 0.
- Single-cycle ops: out_valid is high in the cycle after the accept edge (latency 1).
- mult/div latency: out_valid rises WIDTH+1 edges after the accept edge (33 at WIDTH = 32). in_ready is low from the accept edge until FIX completes, and is high again in the same cycle out_valid is high.
- out_valid is never held for more than one cycle. There is no output backpressure.
- Reset asserted mid-operation aborts immediately: all outputs and HI/LO return to their reset values and no out_valid follows.
- Flags are 0 whenever out_valid is 0.

## Structure

- Shared package alu_pkg holds the op-code localparams (OP_ADD … OP_SLTU) and the state enum (IDLE, MUL, DIV, FIX).
- One sub-module, alu_muldiv, holds the iterative engine: counter, accumulator/remainder, sign fix-up. It exposes start/done/hi/lo to alu_seq.
- alu_seq keeps the single-cycle logic, the handshake, the HI/LO registers and the output registers.

## Test plan

- sra, reg1 = 0x80000000, shamt = 4 → result 0xF8000000 one cycle after accept. srl with the same inputs → 0x08000000.
- add 0x7FFFFFFF + 1 → result 0x80000000, overflow 1. addu with the same inputs → 0x80000000, overflow 0.
- slt vs sltu, reg1 = 0xFFFFFFFF, reg2 = 1 → slt 1, sltu 0. Issue back-to-back and check out_valid on consecutive cycles.
- mult −3 × 5 → out_valid exactly 33 cycles after accept, in_ready low throughout. Then mfhi → 0xFFFFFFFF and mflo → 0xFFFFFFF1. multu 0xFFFFFFFF × 2 → HI 1, LO 0xFFFFFFFE.
- div −7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. Then divu 7 / 0 → div_by_zero 1 with latency 1, and mfhi/mflo still return the previous values.
- Assert rst 10 cycles into a mult → in_ready 1, out_valid 0, HI/LO read back as 0, and no out_valid pulse afterwards.
